// File: rtl/audio_nios_key_pio_in.sv
// Avalon-MM input PIO for the DE-series keys/switches: synchronise, debounce,
// capture edges per bit and raise a maskable interrupt to the Nios II.
module audio_nios_key_pio_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam logic [WIDTH-1:0] IDLE = (IDLE_LEVEL != 0) ? '1 : '0;

  logic [WIDTH-1:0] sync1, sync2, deb, prev;
  logic [WIDTH-1:0] irq_mask, edge_capture;
  logic [WIDTH-1:0] rise, fall, evt, clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  // Only the low WIDTH bits of writedata carry register content.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) deb <= IDLE;
        else          deb <= sync2;
      end
    end else begin : g_debounce
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
      logic [CNT_W-1:0] cnt [WIDTH];

      // A bit only follows sync2 after it has disagreed with deb for
      // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          deb <= IDLE;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == deb[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
              deb[i] <= sync2[i];
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  assign rise = deb & ~prev;
  assign fall = ~deb & prev;

  always_comb begin
    evt = '0;
    case (EDGE_TYPE)
      0:       evt = rise;
      1:       evt = fall;
      default: evt = rise | fall;
    endcase
  end

  assign wr_en = chipselect && !write_n;
  assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // New events are OR-ed in after the clear so a same-cycle set always wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= IDLE;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      prev         <= deb;
      edge_capture <= (edge_capture & ~clr) | evt;
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = deb;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_audio_nios_key_pio_in.sv
// Self-checking bench for audio_nios_key_pio_in with a 4-cycle debounce and
// falling-edge capture; read expectations flow through a scoreboard queue.
module tb_audio_nios_key_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  audio_nios_key_pio_in #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, outputs are sampled there too.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] pins);
    in_port = pins;
  endtask

  task automatic sampleRead(input string tag, input logic [31:0] exp);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick(1);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checkOutput(t, readdata, e);
  endtask

  task automatic busRead(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    address = addr;
    sampleRead(tag, exp);
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic checkIrq(input string tag, input logic exp);
    checkOutput(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  initial begin
    logic [31:0] reset_tbl [4];
    reset_tbl = '{32'hF, 32'h0, 32'h0, 32'h0};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    applyStimulus(4'hF);
    tick(3);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkIrq("reset_irq_held", 1'b0);
    reset_n = 1'b1;

    // Idle keys: every register reads its reset value for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      busRead(2'(i % 4), reset_tbl[i % 4], "reset_reg");
      checkIrq("reset_irq", 1'b0);
    end
    busWrite(2'd0, 32'h0);
    busRead(2'd0, 32'hF, "data_write_ignored");

    // Clean press of key 1: deb changes on the 6th edge, capture on the 7th.
    address = 2'd0;
    applyStimulus(4'hD);
    tick(5);
    sampleRead("data_before_debounce", 32'hF);
    address = 2'd3;
    sampleRead("edgecap_preset_read", 32'h0);
    busRead(2'd3, 32'h2, "edgecap_press");
    busRead(2'd0, 32'hD, "data_press");
    checkIrq("irq_masked", 1'b0);
    busWrite(2'd2, 32'h2);
    checkIrq("irq_after_mask", 1'b1);
    busRead(2'd2, 32'h2, "mask_read");

    // Bounces shorter than the debounce window are rejected.
    busWrite(2'd3, 32'hF);
    busRead(2'd3, 32'h0, "edgecap_cleared");
    checkIrq("irq_cleared", 1'b0);
    applyStimulus(4'hC); tick(2);
    applyStimulus(4'hD); tick(2);
    applyStimulus(4'hC); tick(2);
    applyStimulus(4'hD); tick(10);
    busRead(2'd0, 32'hD, "bounce_data");
    busRead(2'd3, 32'h0, "bounce_edgecap");
    applyStimulus(4'hC); tick(10);
    busRead(2'd0, 32'hC, "stable_press_data");
    busRead(2'd3, 32'h1, "stable_press_edgecap");
    checkIrq("irq_unmasked_bit", 1'b0);

    // Releases are not captured; write-1-to-clear only touches set bits.
    applyStimulus(4'hF); tick(10);
    busRead(2'd0, 32'hF, "release_data");
    busRead(2'd3, 32'h1, "release_no_capture");
    applyStimulus(4'hC); tick(10);
    busRead(2'd3, 32'h3, "two_captures");
    checkIrq("irq_two", 1'b1);
    busWrite(2'd3, 32'h1);
    busRead(2'd3, 32'h2, "w1c_bit0");
    checkIrq("irq_after_w1c", 1'b1);
    busWrite(2'd3, 32'h0);
    busRead(2'd3, 32'h2, "w0_no_change");
    busWrite(2'd2, 32'h1);
    checkIrq("irq_mask_off", 1'b0);
    busWrite(2'd2, 32'hFFFF_FFF2);
    busRead(2'd2, 32'h2, "mask_upper_ignored");
    checkIrq("irq_mask_on", 1'b1);
    busWrite(2'd3, 32'hFFFF_FFFF);
    busRead(2'd3, 32'h0, "w1c_all");
    checkIrq("irq_none", 1'b0);

    // Key 2 falls so its capture lands on the same edge as a clear of bit 2.
    applyStimulus(4'h8);
    tick(6);
    busWrite(2'd3, 32'h4);
    busRead(2'd3, 32'h4, "collision_set_wins");
    busWrite(2'd3, 32'h4);
    busRead(2'd3, 32'h0, "clear_after_collision");

    // Reset in the middle of a key 3 debounce, released with the key held.
    applyStimulus(4'h0);
    tick(2);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_readdata", readdata, 32'h0);
    checkIrq("midreset_irq", 1'b0);
    tick(2);
    address = 2'd0;
    reset_n = 1'b1;
    tick(5);
    sampleRead("post_reset_data_hold", 32'hF);
    address = 2'd3;
    sampleRead("post_reset_no_edge", 32'h0);
    busRead(2'd3, 32'hF, "post_reset_edgecap");
    busRead(2'd0, 32'h0, "post_reset_data");
    busRead(2'd2, 32'h0, "post_reset_mask");
    checkIrq("post_reset_irq", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_nios_key_pio_in.md
Name: audio_nios_key_pio_in

Overview:
- Avalon-MM slave input port (PIO reader) that samples the DE-series pushbuttons and switches and presents them to the Nios II.
- It is the read-side counterpart of the hex-display output ports.
- Per bit: synchronises, debounces, edge-captures and raises a maskable interrupt.
- Sits on the audio_nios system interconnect alongside the output PIOs.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before a bit's debounced value changes. 0 bypasses debounce.
- EDGE_TYPE, 1, captured edge: 0 rising, 1 falling, 2 any.
- IDLE_LEVEL, 1, reset value of synchroniser, debounced and previous-value registers (1 = active-low keys).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  2  register select
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- in_port  input  WIDTH  raw asynchronous pins
- readdata  output  32  registered read data
- irq  output  1  interrupt request, active-high

Behaviour:
- Reset and clock: reset is reset_n, asynchronous, active-low; clock is clk. All state is in the clk domain.
- Reset values: readdata=0, irq=0, irq_mask=0, edge_capture=0, debounce counters=0. sync1, sync2, deb and prev all equal {WIDTH{IDLE_LEVEL}}.
- Synchroniser: in_port -> sync1 -> sync2, a two-flop chain. No logic between the flops.
- Debounce (per bit i):
  - If sync2[i]==deb[i], cnt[i] clears to 0.
  - Otherwise cnt[i] increments. When cnt[i]==DEBOUNCE_CYCLES-1, deb[i] takes sync2[i] and cnt[i] clears.
  - Any glitch back to the deb value restarts the count.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - DEBOUNCE_CYCLES=0: deb=sync2 each cycle.
- Edge detect: prev<=deb every cycle.
  - rise=deb&~prev; fall=~deb&prev; evt selected by EDGE_TYPE (any = rise|fall).
- Register map (32-bit words, unused bits read 0):
  - 0 DATA: RO, deb zero-extended. Writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK: RW, WIDTH bits.
  - 3 EDGECAP: read returns edge_capture. Write-1-to-clear per bit: writedata[i]=1 clears bit i, 0 leaves it.
- Write: accepted on a cycle with chipselect && !write_n. Takes effect next edge. No wait states.
- Read: readdata <= mux(address) every cycle. Data is valid the cycle after address is presented (read latency 1).
- Edge capture: edge_capture[i] sets when evt[i]=1.
  - Simultaneous set and write-1-clear on the same bit: set wins, so no event is lost.
  - Bits stay set until cleared. They do not self-clear on read.
- irq = |(edge_capture & irq_mask), driven combinationally from registers.
  - Changing the mask affects irq the cycle after the write.
- Latency from a pin change to deb: 2 synchroniser cycles + DEBOUNCE_CYCLES. One further cycle to edge_capture.
- Reset mid-debounce: the counter is discarded and deb returns to IDLE_LEVEL. No edge is generated on reset release.
- Reading EDGECAP in the same cycle an edge sets a bit: readdata shows the pre-set value. The bit is seen on the next read.
- Writes to the WIDTH..31 bits of IRQMASK/EDGECAP are ignored.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, IDLE_LEVEL=1):
1. Reset check: release reset with in_port=4'hF -> read addr0=0x0000000F, addr2=0, addr3=0, irq=0 for 20 cycles.
2. Clean press: in_port[1] held 1->0 -> DATA=0xD after 2+4 cycles. EDGECAP=0x2 one cycle later. irq stays 0 (mask=0). Write IRQMASK=0x2 -> irq=1 the next cycle.
3. Bounce rejection: in_port[0] toggled 0,1,0,1 with 2-cycle periods, then held 1 -> DATA bit0 stays 1, EDGECAP=0. Then held 0 for 6 cycles -> one capture, EDGECAP=0x1.
4. Write-1-to-clear: EDGECAP=0x3, write 0x1 to addr3 -> EDGECAP=0x2 and irq tracks the mask. Write 0x0 -> no change.
5. Set/clear collision: schedule a falling edge on bit2 in the same cycle as a write of 0x4 to addr3 -> EDGECAP bit2 remains 1.
6. Reset mid-debounce: assert reset_n=0 two cycles into a bit3 press, release with in_port[3]=0 -> DATA bit3 reads 1 until 2+4 cycles after release, then 0 with EDGECAP bit3=1.
